// File: rtl/mmio_timer_bank.sv
// Bank of independent down-counting timers behind a shared 64-bit MMIO bus.
// Interrupt support is compiled in only when MMIO_TIMER_IRQ_EN is defined.
module mmio_timer_bank #(
    parameter logic [63:0] BASE_ADDR      = 64'h0000_0000_0000_2000,
    parameter int          CHANNELS       = 4,
    parameter int          COUNT_WIDTH    = 32,
    parameter int          PRESCALE_WIDTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] address,
    inout  wire  [63:0] data,
    input  logic        read,
    input  logic        write,
    output logic        irq
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(32 * CHANNELS);
    localparam logic [COUNT_WIDTH-1:0]    CNT_ONE = COUNT_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = PRESCALE_WIDTH'(1);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_LOAD   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       mode;
    logic [CHANNELS-1:0]       flag;
`ifdef MMIO_TIMER_IRQ_EN
    logic [CHANNELS-1:0]       irq_en;
`endif
    logic [PRESCALE_WIDTH-1:0] prescale  [CHANNELS];
    logic [PRESCALE_WIDTH-1:0] presc_cnt [CHANNELS];
    logic [COUNT_WIDTH-1:0]    load      [CHANNELS];
    logic [COUNT_WIDTH-1:0]    count     [CHANNELS];

    logic [63:0]         offset;
    logic                hit;
    logic [CH_W-1:0]     sel_ch;
    reg_e                reg_sel;
    logic [CHANNELS-1:0] wr_ctrl, wr_load, wr_status, tick, expire;
    logic [63:0]         rdata;

    // Misaligned addresses inside the window are treated as a miss.
    assign offset  = address - BASE_ADDR;
    assign hit     = (address >= BASE_ADDR) && (address < END_ADDR) && (offset[2:0] == 3'b000);
    assign sel_ch  = offset[5 +: CH_W];
    assign reg_sel = reg_e'(offset[4:3]);

    // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_ctrl   = '0;
        wr_load   = '0;
        wr_status = '0;
        tick      = '0;
        expire    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_ctrl[i]   = hit && write && (sel_ch == CH_W'(i)) && (reg_sel == REG_CTRL);
            wr_load[i]   = hit && write && (sel_ch == CH_W'(i)) && (reg_sel == REG_LOAD);
            wr_status[i] = hit && write && (sel_ch == CH_W'(i)) && (reg_sel == REG_STATUS);
            tick[i]      = enable[i] && (presc_cnt[i] == prescale[i]);
            // A LOAD write in the same cycle swallows the tick, so it can never expire.
            expire[i]    = tick[i] && (count[i] == CNT_ONE) && !wr_load[i];
        end
    end

    // NOTE: non-blocking assignments for all state; the per-channel arrays are
    // register banks (not RAM), so they are cleared by the async reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable <= '0;
            mode   <= '0;
            flag   <= '0;
`ifdef MMIO_TIMER_IRQ_EN
            irq_en <= '0;
`endif
            for (int i = 0; i < CHANNELS; i++) begin
                prescale[i]  <= '0;
                presc_cnt[i] <= '0;
                load[i]      <= '0;
                count[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_load[i] || (wr_ctrl[i] && data[0] && !enable[i])) begin
                    presc_cnt[i] <= '0;
                end else if (enable[i]) begin
                    presc_cnt[i] <= tick[i] ? '0 : presc_cnt[i] + PRE_ONE;
                end

                if (wr_load[i]) begin
                    load[i]  <= data[COUNT_WIDTH-1:0];
                    count[i] <= data[COUNT_WIDTH-1:0];
                end else if (tick[i] && (count[i] > CNT_ONE)) begin
                    count[i] <= count[i] - CNT_ONE;
                end else if (expire[i]) begin
                    count[i] <= mode[i] ? load[i] : '0;
                end

                // A same-cycle CTRL write overrides the one-shot self-disable.
                if (wr_ctrl[i]) begin
                    enable[i]   <= data[0];
                    mode[i]     <= data[1];
                    prescale[i] <= data[16 +: PRESCALE_WIDTH];
`ifdef MMIO_TIMER_IRQ_EN
                    irq_en[i]   <= data[2];
`endif
                end else if (expire[i] && !mode[i]) begin
                    enable[i] <= 1'b0;
                end

                if (expire[i]) begin
                    flag[i] <= 1'b1;
                end else if (wr_status[i] && data[0]) begin
                    flag[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL: begin
                rdata[0] = enable[sel_ch];
                rdata[1] = mode[sel_ch];
`ifdef MMIO_TIMER_IRQ_EN
                rdata[2] = irq_en[sel_ch];
`endif
                rdata[16 +: PRESCALE_WIDTH] = prescale[sel_ch];
            end
            REG_LOAD:   rdata[COUNT_WIDTH-1:0] = load[sel_ch];
            REG_COUNT:  rdata[COUNT_WIDTH-1:0] = count[sel_ch];
            REG_STATUS: rdata[0] = flag[sel_ch];
            default:    rdata = '0;
        endcase
    end

    assign data = (reset && read && !write && hit) ? rdata : {64{1'bz}};

`ifdef MMIO_TIMER_IRQ_EN
    assign irq = |(flag & irq_en);
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed bench for mmio_timer_bank; the data bus is pulled up so an undriven bus reads all ones.
module tb_mmio_timer_bank;

    localparam logic [63:0] BASE  = 64'h2000;
    localparam logic [63:0] HIZ   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] OFF_CTRL = 0, OFF_LOAD = 8, OFF_COUNT = 16, OFF_STATUS = 24;
`ifdef MMIO_TIMER_IRQ_EN
    localparam logic        IRQ_ON   = 1'b1;
    localparam logic [63:0] CH2_CTRL = 64'h7;
`else
    localparam logic        IRQ_ON   = 1'b0;
    localparam logic [63:0] CH2_CTRL = 64'h3;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        irq;
    logic [63:0] tb_data = '0;
    logic        tb_drive = 1'b0;
    tri1  [63:0] data;

    int tests = 0;
    int failures = 0;
    logic [63:0] rd;

    assign data = tb_drive ? tb_data : {64{1'bz}};

    mmio_timer_bank dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .data    (data),
        .read    (read),
        .write   (write),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] reg_addr(input int ch, input logic [63:0] off);
        return BASE + 64'(32 * ch) + off;
    endfunction

    // Consumes exactly one rising edge; returns 1 time unit after it.
    task automatic bus_write(input logic [63:0] addr, input logic [63:0] val);
        @(negedge clock);
        address  = addr;
        tb_data  = val;
        tb_drive = 1'b1;
        write    = 1'b1;
        @(posedge clock);
        #1;
        write    = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [63:0] addr, output logic [63:0] val);
        address = addr;
        read    = 1'b1;
        #1;
        val     = data;
        read    = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #2;
        bus_read(reg_addr(0, OFF_CTRL), rd);
        check("hiz_in_reset", rd, HIZ);
        check("irq_in_reset", 64'(irq), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        bus_read(reg_addr(0, OFF_CTRL), rd);
        check("rst_ctrl0", rd, 64'h0);
        bus_read(reg_addr(3, OFF_COUNT), rd);
        check("rst_count3", rd, 64'h0);

        // ch0 periodic, prescale 0
        bus_write(reg_addr(0, OFF_LOAD), 64'd3);
        bus_write(reg_addr(0, OFF_CTRL), 64'h3);
        bus_read(reg_addr(0, OFF_COUNT), rd);  check("ch0_count_e1", rd, 64'd3);
        wait_edges(1);
        bus_read(reg_addr(0, OFF_COUNT), rd);  check("ch0_count_e2", rd, 64'd2);
        wait_edges(1);
        bus_read(reg_addr(0, OFF_COUNT), rd);  check("ch0_count_e3", rd, 64'd1);
        bus_read(reg_addr(0, OFF_STATUS), rd); check("ch0_flag_e3", rd, 64'd0);
        wait_edges(1);
        bus_read(reg_addr(0, OFF_COUNT), rd);  check("ch0_reload_e4", rd, 64'd3);
        bus_read(reg_addr(0, OFF_STATUS), rd); check("ch0_flag_e4", rd, 64'd1);
        bus_write(reg_addr(0, OFF_STATUS), 64'h1);
        bus_read(reg_addr(0, OFF_STATUS), rd); check("ch0_w1c", rd, 64'd0);
        bus_read(reg_addr(0, OFF_COUNT), rd);  check("ch0_count_e5", rd, 64'd2);
        wait_edges(2);
        bus_read(reg_addr(0, OFF_STATUS), rd); check("ch0_flag_e7", rd, 64'd1);
        bus_read(reg_addr(0, OFF_COUNT), rd);  check("ch0_reload_e7", rd, 64'd3);
        bus_write(reg_addr(0, OFF_CTRL), 64'h0);
        wait_edges(3);
        bus_read(reg_addr(0, OFF_COUNT), rd);  check("ch0_frozen", rd, 64'd2);

        // ch1 one-shot, prescale 2
        bus_write(reg_addr(1, OFF_LOAD), 64'd2);
        bus_write(reg_addr(1, OFF_CTRL), 64'h0002_0001);
        bus_read(reg_addr(1, OFF_CTRL), rd);   check("ch1_ctrl", rd, 64'h0002_0001);
        wait_edges(5);
        bus_read(reg_addr(1, OFF_COUNT), rd);  check("ch1_count_e6", rd, 64'd1);
        bus_read(reg_addr(1, OFF_STATUS), rd); check("ch1_flag_e6", rd, 64'd0);
        wait_edges(1);
        bus_read(reg_addr(1, OFF_COUNT), rd);  check("ch1_count_e7", rd, 64'd0);
        bus_read(reg_addr(1, OFF_STATUS), rd); check("ch1_flag_e7", rd, 64'd1);
        bus_read(reg_addr(1, OFF_CTRL), rd);   check("ch1_ctrl_off", rd, 64'h0002_0000);
        wait_edges(3);
        bus_read(reg_addr(1, OFF_COUNT), rd);  check("ch1_stays0", rd, 64'd0);
        check("irq_no_en", 64'(irq), 64'h0);

        // ch2 interrupt and W1C/expiry collision
        bus_write(reg_addr(2, OFF_LOAD), 64'd1);
        bus_write(reg_addr(2, OFF_CTRL), 64'h5);
        wait_edges(1);
        bus_read(reg_addr(2, OFF_STATUS), rd); check("ch2_flag", rd, 64'd1);
        check("ch2_irq_set", 64'(irq), 64'(IRQ_ON));
        bus_write(reg_addr(2, OFF_STATUS), 64'h1);
        check("ch2_irq_clr", 64'(irq), 64'h0);
        bus_write(reg_addr(2, OFF_LOAD), 64'd2);
        bus_write(reg_addr(2, OFF_CTRL), 64'h7);
        bus_read(reg_addr(2, OFF_CTRL), rd);   check("ch2_ctrl", rd, CH2_CTRL);
        wait_edges(2);
        bus_read(reg_addr(2, OFF_STATUS), rd); check("ch2_flag_p", rd, 64'd1);
        bus_write(reg_addr(2, OFF_STATUS), 64'h1);
        bus_read(reg_addr(2, OFF_STATUS), rd); check("ch2_w1c", rd, 64'd0);
        bus_write(reg_addr(2, OFF_STATUS), 64'h1);
        bus_read(reg_addr(2, OFF_STATUS), rd); check("ch2_w1c_vs_exp", rd, 64'd1);
        bus_read(reg_addr(2, OFF_COUNT), rd);  check("ch2_count_run", rd, 64'd2);
        check("ch2_irq_again", 64'(irq), 64'(IRQ_ON));

        // LOAD beats a same-cycle tick
        bus_write(reg_addr(2, OFF_LOAD), 64'd5);
        bus_read(reg_addr(2, OFF_COUNT), rd);  check("ch2_load_prio", rd, 64'd5);
        bus_read(reg_addr(2, OFF_STATUS), rd); check("ch2_flag_kept", rd, 64'd1);

        // Decode window and read/write collision
        bus_read(BASE + 64'd128, rd);          check("hiz_above", rd, HIZ);
        bus_read(BASE - 64'd8, rd);            check("hiz_below", rd, HIZ);
        @(negedge clock);
        address = reg_addr(3, OFF_COUNT);
        read    = 1'b1;
        write   = 1'b1;
        #1;
        check("hiz_rd_wr", data, HIZ);
        read    = 1'b0;
        write   = 1'b0;
        bus_read(reg_addr(3, OFF_COUNT), rd);  check("ch3_count_ro", rd, 64'd0);

        // Reset in the middle of a count
        wait_edges(1);
        bus_read(reg_addr(2, OFF_COUNT), rd);  check("ch2_pre_rst", rd, 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check("irq_rst", 64'(irq), 64'h0);
        bus_read(reg_addr(2, OFF_COUNT), rd);  check("hiz_rst_mid", rd, HIZ);
        wait_edges(2);
        @(negedge clock);
        reset = 1'b1;
        wait_edges(3);
        for (int ch = 0; ch < 4; ch++) begin
            bus_read(reg_addr(ch, OFF_CTRL), rd);   check($sformatf("post_ctrl%0d", ch), rd, 64'h0);
            bus_read(reg_addr(ch, OFF_LOAD), rd);   check($sformatf("post_load%0d", ch), rd, 64'h0);
            bus_read(reg_addr(ch, OFF_COUNT), rd);  check($sformatf("post_count%0d", ch), rd, 64'h0);
            bus_read(reg_addr(ch, OFF_STATUS), rd); check($sformatf("post_flag%0d", ch), rd, 64'h0);
        end
        check("post_irq", 64'(irq), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mmio_timer_bank.md
MMIO_TIMER_BANK -- requirements
Module: mmio_timer_bank

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h0000_0000_0000_2000, byte address of channel 0.
REQ-002 SHALL have parameter CHANNELS, default 4, number of timer channels (1..16).
REQ-003 SHALL have parameter COUNT_WIDTH, default 32, width of LOAD and COUNT registers (1..64).
REQ-004 SHALL have parameter PRESCALE_WIDTH, default 16, width of the per-channel prescale divisor (1..32).
REQ-005 SHALL have port clock  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port address  input  64  shared address bus.
REQ-008 SHALL have port data  inout  64  shared data bus, high-Z unless this block is read.
REQ-009 SHALL have port read  input  1  bus read strobe.
REQ-010 SHALL have port write  input  1  bus write strobe, sampled on rising edge.
REQ-011 SHALL have port irq  output  1  level interrupt, OR of enabled channel flags.

Function
REQ-012 SHALL decode channel n at BASE_ADDR + 32*n; offsets 0 CTRL, 8 LOAD, 16 COUNT (read-only), 24 STATUS; addresses outside [BASE_ADDR, BASE_ADDR+32*CHANNELS) are ignored.
REQ-013 SHALL lay out CTRL as: bit0 enable, bit1 mode (1 periodic, 0 one-shot), bit2 irq_en, bits [16+PRESCALE_WIDTH-1:16] prescale; all other bits read 0.
REQ-014 SHALL drive data combinationally, zero-extended, while read=1, write=0 and address decodes; otherwise data SHALL be high-Z.
REQ-015 SHALL, when read and write are both 1, perform the write and leave data high-Z.
REQ-016 SHALL, on a LOAD write, set load and count to data[COUNT_WIDTH-1:0] and clear the channel prescaler.
REQ-017 SHALL, on a CTRL write that changes enable 0->1, clear the prescaler; count is not modified.
REQ-018 SHALL, while enabled, increment the prescaler each cycle and emit a tick in the cycle the prescaler equals prescale, then reset it to 0 (prescale=0 gives one tick per cycle).
REQ-019 SHALL on a tick with count>1 decrement count.
REQ-020 SHALL on a tick with count==1 (expiry) set STATUS bit0; periodic: count<=load; one-shot: count<=0 and enable<=0.
REQ-021 SHALL on a tick with count==0 take no action (no flag, no reload).
REQ-022 SHALL clear STATUS bit0 on a STATUS write with data bit0=1 (write-1-to-clear); an expiry in the same cycle SHALL win (flag stays set).
REQ-023 SHALL give a LOAD write priority over a same-cycle tick (tick discarded).
REQ-024 SHALL drive irq = OR over channels of (flag AND irq_en), registered-free combinational from state.
REQ-025 SHALL keep channels fully independent; disabling a channel freezes count and prescaler.

Reset
REQ-026 SHALL on reset=0 asynchronously clear CTRL, LOAD, COUNT, prescaler and flag of every channel.
REQ-027 SHALL hold irq=0 and data high-Z during reset; reset mid-count abandons the count with no flag.

Configuration
REQ-028 SHALL compile interrupt support only when MMIO_TIMER_IRQ_EN is defined; with it, REQ-011/REQ-024 apply.
REQ-029 SHALL, without MMIO_TIMER_IRQ_EN, tie irq to 0, make CTRL bit2 read 0 and ignore writes to it; flags still set and clear.

Verification
REQ-030 SHALL cover: ch0 LOAD=3, CTRL=0x3 (periodic, prescale 0) -> flag sets on 3rd edge after enable, count reloads 3, repeats every 3 cycles.
REQ-031 SHALL cover: ch1 LOAD=2, CTRL=0x0002_0001 (one-shot, prescale 2) -> expiry 6 cycles after enable, count=0, CTRL bit0 reads 0.
REQ-032 SHALL cover: ch2 flag set, CTRL bit2=1 -> irq=1; STATUS write 0x1 -> irq=0 next cycle; W1C coinciding with expiry -> flag remains 1.
REQ-033 SHALL cover: read at BASE_ADDR+16 of running channel returns count zero-extended; read at BASE_ADDR+32*CHANNELS -> data high-Z.
REQ-034 SHALL cover: reset=0 asserted mid-count -> all registers read 0 after release, irq=0, no spurious flag.
